// File: rtl/kbd_key_fifo_if.sv
// Key-line inputs and FIFO read-side signals of kbd_key_fifo.
// The master modport drives the keys and the pop request; the slave is the keyboard block.
interface kbd_key_fifo_if #(
  parameter int unsigned KEYS  = 128,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [KEYS-1:0]  Keys;
  logic             Clear;
  logic             RdEn;
  logic [7:0]       RdData;
  logic             Empty;
  logic             Full;
  logic [CNT_W-1:0] Count;
  logic             Overflow;
  logic             MultiErr;
  logic             EtxSeen;

  modport master (
    output Keys, Clear, RdEn,
    input  RdData, Empty, Full, Count, Overflow, MultiErr, EtxSeen
  );

  modport slave (
    input  Keys, Clear, RdEn,
    output RdData, Empty, Full, Count, Overflow, MultiErr, EtxSeen
  );
endinterface

// File: rtl/kbd_key_fifo.sv
// One-hot keyboard encoder with debounce tracker and first-word-fall-through code FIFO.
// Optional auto-repeat of a held key is enabled by defining KBD_REPEAT_EN.
module kbd_key_fifo #(
  parameter int unsigned KEYS        = 128,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned DEBOUNCE    = 1,
  parameter int unsigned REPEAT_DLY  = 500,
  parameter int unsigned REPEAT_RATE = 50
) (
  input logic           Clk,
  input logic           Rst,
  kbd_key_fifo_if.slave bus
);
  localparam int unsigned CODE_W  = $clog2(KEYS);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned DB_W    = $clog2(DEBOUNCE + 1);
  localparam bit          HAS_ETX = (KEYS > 3);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMING, ST_HELD, ST_ERR} state_t;

  logic [KEYS-1:0]   r_s;
  state_t            r_state, w_state_nxt;
  logic [DB_W-1:0]   r_cnt, w_cnt_nxt;
  logic [DB_W:0]     w_cnt_inc;
  logic [CODE_W-1:0] r_cand, w_cand_nxt;
  logic [CODE_W-1:0] w_code;
  logic              w_zero, w_one, w_multi;
  logic              w_push, w_start;
  logic              w_clr;

  logic [CODE_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic              r_empty, r_full;
  logic [7:0]        r_rd_data;
  logic              r_overflow, r_multi_err, r_etx;
  logic              w_pop, w_push_ok;

`ifdef KBD_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  logic [REP_W-1:0] r_rep, w_rep_nxt;
  logic [REP_W:0]   w_rep_inc;
  logic             r_rep_first, w_rep_first_nxt;
`else
  logic w_unused_rep;
  assign w_unused_rep = ^{REPEAT_DLY[0], REPEAT_RATE[0]};
`endif

  assign w_clr   = !Rst || bus.Clear;
  assign w_zero  = (r_s == '0);
  assign w_one   = $onehot(r_s);
  assign w_multi = !w_zero && !w_one;

  // Binary index of the single high key line
  always_comb begin
    w_code = '0;
    for (int i = 0; i < KEYS; i++) begin
      if (r_s[i]) w_code = w_code | CODE_W'(i);
    end
  end

  // Tracker next state and push request
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_push      = 1'b0;
    w_start     = 1'b0;
    w_cnt_inc   = (DB_W+1)'(r_cnt) + (DB_W+1)'(1);
`ifdef KBD_REPEAT_EN
    w_rep_nxt       = r_rep;
    w_rep_first_nxt = r_rep_first;
    w_rep_inc       = (REP_W+1)'(r_rep) + (REP_W+1)'(1);
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_multi)    w_state_nxt = ST_ERR;
        else if (w_one) w_start     = 1'b1;
      end
      ST_ARMING: begin
        if (w_multi)     w_state_nxt = ST_ERR;
        else if (w_zero) w_state_nxt = ST_IDLE;
        else if (w_code == r_cand) begin
          if (w_cnt_inc >= (DB_W+1)'(DEBOUNCE)) begin
            w_push      = 1'b1;
            w_state_nxt = ST_HELD;
`ifdef KBD_REPEAT_EN
            w_rep_nxt       = '0;
            w_rep_first_nxt = 1'b1;
`endif
          end else begin
            w_cnt_nxt = DB_W'(w_cnt_inc);
          end
        end else w_start = 1'b1;
      end
      ST_HELD: begin
        if (w_multi)     w_state_nxt = ST_ERR;
        else if (w_zero) w_state_nxt = ST_IDLE;
        else if (w_code == r_cand) begin
`ifdef KBD_REPEAT_EN
          if ((r_rep_first && (w_rep_inc == (REP_W+1)'(REPEAT_DLY))) ||
              (!r_rep_first && (w_rep_inc == (REP_W+1)'(REPEAT_RATE)))) begin
            w_push          = 1'b1;
            w_rep_nxt       = '0;
            w_rep_first_nxt = 1'b0;
          end else begin
            w_rep_nxt = REP_W'(w_rep_inc);
          end
`endif
        end else w_start = 1'b1;
      end
      default: begin
        if (w_zero) w_state_nxt = ST_IDLE;
      end
    endcase
    // New candidate key: with DEBOUNCE=1 it is accepted on the first sample
    if (w_start) begin
      w_cand_nxt = w_code;
      w_cnt_nxt  = DB_W'(1);
      if (DEBOUNCE <= 1) begin
        w_push      = 1'b1;
        w_state_nxt = ST_HELD;
      end else begin
        w_state_nxt = ST_ARMING;
      end
`ifdef KBD_REPEAT_EN
      w_rep_nxt       = '0;
      w_rep_first_nxt = 1'b1;
`endif
    end
  end

  // Sample register and tracker state
  always_ff @(posedge Clk) begin
    if (w_clr) begin
      r_s     <= '0;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
`ifdef KBD_REPEAT_EN
      r_rep       <= '0;
      r_rep_first <= 1'b1;
`endif
    end else begin
      r_s     <= bus.Keys;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cand  <= w_cand_nxt;
`ifdef KBD_REPEAT_EN
      r_rep       <= w_rep_nxt;
      r_rep_first <= w_rep_first_nxt;
`endif
    end
  end

  assign w_pop        = bus.RdEn && !r_empty;
  assign w_push_ok    = w_push && (!r_full || w_pop);
  assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
  assign w_count_nxt  = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);

  always_ff @(posedge Clk) begin
    if (!w_clr && w_push_ok) r_mem[r_wr_ptr] <= w_cand_nxt;
  end

  // FIFO pointers, status and registered head (bypass when the head is written this edge)
  always_ff @(posedge Clk) begin
    if (w_clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_rd_data   <= '0;
      r_overflow  <= 1'b0;
      r_multi_err <= 1'b0;
      r_etx       <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_empty  <= (w_count_nxt == '0);
      r_full   <= (w_count_nxt == CNT_W'(DEPTH));
      if (w_count_nxt == '0)
        r_rd_data <= '0;
      else if (w_push_ok && (r_wr_ptr == w_rd_ptr_nxt))
        r_rd_data <= 8'(w_cand_nxt);
      else
        r_rd_data <= 8'(r_mem[w_rd_ptr_nxt]);
      r_overflow  <= r_overflow || (w_push && !w_push_ok);
      r_multi_err <= r_multi_err || w_multi;
      r_etx       <= HAS_ETX && w_push_ok && (w_cand_nxt == CODE_W'(3));
    end
  end

  assign bus.RdData   = r_rd_data;
  assign bus.Empty    = r_empty;
  assign bus.Full     = r_full;
  assign bus.Count    = r_count;
  assign bus.Overflow = r_overflow;
  assign bus.MultiErr = r_multi_err;
  assign bus.EtxSeen  = r_etx;
endmodule

// File: tb/tb_kbd_key_fifo.sv
// Directed bench for kbd_key_fifo with a queue of expected FIFO codes.
// Covers the held-key auto-repeat case when KBD_REPEAT_EN is defined.
module tb_kbd_key_fifo;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [7:0] exp_q [$];

  kbd_key_fifo_if #(.KEYS(128), .DEPTH(16)) bus ();

  kbd_key_fifo #(
    .KEYS(128), .DEPTH(16), .DEBOUNCE(1), .REPEAT_DLY(10), .REPEAT_RATE(4)
  ) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One key held for `cycles` edges followed by a one-cycle zero gap
  task automatic press(input int code, input int cycles);
    bus.Keys       = '0;
    bus.Keys[code] = 1'b1;
    repeat (cycles) tick();
    bus.Keys = '0;
    tick();
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] exp;
    chk({tag, "_avail"}, 32'(exp_q.size() != 0), 32'd1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hEE;
    chk({tag, "_nonempty"}, 32'(bus.Empty), 32'd0);
    chk(tag, 32'(bus.RdData), 32'(exp));
    bus.RdEn = 1'b1;
    tick();
    bus.RdEn = 1'b0;
  endtask

  initial begin
    logic [7:0] label_s [9];
    n_checks  = 0;
    n_errors  = 0;
    label_s   = '{8'h6C, 8'h61, 8'h62, 8'h65, 8'h6C, 8'h20, 8'h73, 8'h72, 8'h0A};
    rst       = 1'b0;
    bus.Keys  = '0;
    bus.Keys[5] = 1'b1;
    bus.Clear = 1'b0;
    bus.RdEn  = 1'b0;

    // Reset with a key held: nothing pushed
    tick();
    tick();
    chk("rst_empty", 32'(bus.Empty), 32'd1);
    chk("rst_count", 32'(bus.Count), 32'd0);
    chk("rst_full", 32'(bus.Full), 32'd0);
    chk("rst_rddata", 32'(bus.RdData), 32'd0);
    chk("rst_flags", 32'({bus.Overflow, bus.MultiErr, bus.EtxSeen}), 32'd0);
    rst = 1'b1;
    tick();
    bus.Keys = '0;
    exp_q.push_back(8'h05);
    tick();
    chk("post_rst_count", 32'(bus.Count), 32'd1);
    pop_chk("post_rst_key5");
    chk("post_rst_empty", 32'(bus.Empty), 32'd1);

    // Pop while empty is ignored
    bus.RdEn = 1'b1;
    tick();
    bus.RdEn = 1'b0;
    chk("pop_empty_count", 32'(bus.Count), 32'd0);

    // Typed line
    foreach (label_s[i]) begin
      press(int'(label_s[i]), 1);
      exp_q.push_back(label_s[i]);
    end
    chk("label_count", 32'(bus.Count), 32'd9);
    for (int i = 0; i < 9; i++) pop_chk("label_pop");
    chk("label_empty", 32'(bus.Empty), 32'd1);

    // Held key pushes once; key-zero-key pushes twice
    press(8'h73, 2);
    exp_q.push_back(8'h73);
    chk("held_count", 32'(bus.Count), 32'd1);
    press(8'h73, 1);
    press(8'h73, 1);
    exp_q.push_back(8'h73);
    exp_q.push_back(8'h73);
    chk("ss_count", 32'(bus.Count), 32'd3);
    for (int i = 0; i < 3; i++) pop_chk("ss_pop");

    // Two lines high together
    bus.Keys     = '0;
    bus.Keys[65] = 1'b1;
    bus.Keys[66] = 1'b1;
    repeat (3) tick();
    bus.Keys = '0;
    tick();
    chk("multi_err", 32'(bus.MultiErr), 32'd1);
    chk("multi_count", 32'(bus.Count), 32'd0);
    press(8'h78, 1);
    exp_q.push_back(8'h78);
    pop_chk("after_multi_x");
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    chk("clear_multi", 32'(bus.MultiErr), 32'd0);

    // Push and pop on the same edge while empty: push lands
    bus.Keys       = '0;
    bus.Keys[8'h31] = 1'b1;
    tick();
    bus.Keys = '0;
    bus.RdEn = 1'b1;
    tick();
    bus.RdEn = 1'b0;
    exp_q.push_back(8'h31);
    chk("pushpop_empty_count", 32'(bus.Count), 32'd1);
    pop_chk("pushpop_empty_data");

    // Fill to DEPTH, then one dropped press
    for (int i = 0; i < 17; i++) begin
      press(8'h41 + i, 1);
      if (i < 16) exp_q.push_back(8'(8'h41 + i));
    end
    chk("full_flag", 32'(bus.Full), 32'd1);
    chk("full_count", 32'(bus.Count), 32'd16);
    chk("overflow", 32'(bus.Overflow), 32'd1);
    // Push with simultaneous pop while full
    bus.Keys       = '0;
    bus.Keys[8'h61] = 1'b1;
    tick();
    bus.Keys = '0;
    chk("full_head", 32'(bus.RdData), 32'(exp_q.pop_front()));
    bus.RdEn = 1'b1;
    tick();
    bus.RdEn = 1'b0;
    exp_q.push_back(8'h61);
    chk("full_pushpop_count", 32'(bus.Count), 32'd16);
    chk("full_pushpop_full", 32'(bus.Full), 32'd1);
    for (int i = 0; i < 16; i++) pop_chk("drain_pop");
    chk("drain_empty", 32'(bus.Empty), 32'd1);
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    chk("clear_overflow", 32'(bus.Overflow), 32'd0);

    // End-of-text pulse
    bus.Keys    = '0;
    bus.Keys[3] = 1'b1;
    tick();
    bus.Keys = '0;
    chk("etx_before", 32'(bus.EtxSeen), 32'd0);
    tick();
    chk("etx_pulse", 32'(bus.EtxSeen), 32'd1);
    tick();
    chk("etx_drop", 32'(bus.EtxSeen), 32'd0);
    exp_q.push_back(8'h03);
    pop_chk("etx_code");

    // Long hold of 'a'
    press(8'h61, 20);
`ifdef KBD_REPEAT_EN
    repeat (4) exp_q.push_back(8'h61);
    chk("hold_count", 32'(bus.Count), 32'd4);
    for (int i = 0; i < 4; i++) pop_chk("repeat_pop");
`else
    exp_q.push_back(8'h61);
    chk("hold_count", 32'(bus.Count), 32'd1);
    pop_chk("hold_pop");
`endif
    chk("final_empty", 32'(bus.Empty), 32'd1);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
